// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchronizer, mid-bit sampling, one-cycle data_valid / frame_err pulses.
// Latency: 2 sync + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks from rxd_in falling to data_valid.
// No backpressure: data_out must be captured on the data_valid cycle; it holds until the next good frame.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1302
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t        state, state_nxt;
    logic          rx_meta, rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          half_hit, full_hit;
    logic          cnt_clr, shift_en, idx_clr, good_nxt, err_nxt;

    assign half_hit = (cnt == HALF_LAST);
    assign full_hit = (cnt == FULL_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!rxs)                   state_nxt = START;
            START: if (half_hit)               state_nxt = rxs ? IDLE : DATA;
            DATA:  if (full_hit && bit_idx == 3'd7) state_nxt = STOP;
            STOP:  if (full_hit)               state_nxt = rxs ? IDLE : BRK;
            BRK:   if (rxs)                    state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        cnt_clr  = (state == IDLE) || (state == BRK)
                || ((state == START) && half_hit)
                || (((state == DATA) || (state == STOP)) && full_hit);
        shift_en = (state == DATA) && full_hit;
        idx_clr  = (state == START) && half_hit;
        good_nxt = (state == STOP) && full_hit && rxs;
        err_nxt  = (state == STOP) && full_hit && !rxs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shreg      <= 8'h00;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rxd_in;
            rxs        <= rx_meta;
            cnt        <= cnt_clr ? '0 : cnt + CW'(1);
            data_valid <= good_nxt;
            frame_err  <= err_nxt;
            if (idx_clr) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            // LSB arrives first, so shifting right leaves it in bit 0 after eight samples
            if (shift_en) shreg <= {rxs, shreg[7:1]};
            if (good_nxt) data_out <= shreg;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: four instances (1302, 100, 5, 4 clocks/bit) checked against a pulse scoreboard.
module tb_uart_rx;
    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       rst  [NI];
    logic       rxd  [NI];
    logic [7:0] dout [NI];
    logic       dv   [NI];
    logic       fe   [NI];
    logic       busy [NI];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cyc [NI] = '{default: 0};
    logic [7:0] last_good [NI];

    typedef struct {
        int         inst;
        logic       err;
        logic [7:0] dat;
    } exp_t;
    exp_t q[$];

    uart_rx #(.CLKS_PER_BIT(1302)) u0 (.clk(clk), .rst(rst[0]), .rxd_in(rxd[0]), .data_out(dout[0]),
                                       .data_valid(dv[0]), .frame_err(fe[0]), .busy(busy[0]));
    uart_rx #(.CLKS_PER_BIT(100))  u1 (.clk(clk), .rst(rst[1]), .rxd_in(rxd[1]), .data_out(dout[1]),
                                       .data_valid(dv[1]), .frame_err(fe[1]), .busy(busy[1]));
    uart_rx #(.CLKS_PER_BIT(5))    u2 (.clk(clk), .rst(rst[2]), .rxd_in(rxd[2]), .data_out(dout[2]),
                                       .data_valid(dv[2]), .frame_err(fe[2]), .busy(busy[2]));
    uart_rx #(.CLKS_PER_BIT(4))    u3 (.clk(clk), .rst(rst[3]), .rxd_in(rxd[3]), .data_out(dout[3]),
                                       .data_valid(dv[3]), .frame_err(fe[3]), .busy(busy[3]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (dv[i] || fe[i]) begin
                chk("pulse_exclusive", 32'(dv[i] & fe[i]), 32'd0);
                chk("pulse_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("pulse_inst", 32'(i), 32'(e.inst));
                    chk("pulse_is_frame_err", 32'(fe[i]), 32'(e.err));
                    chk("data_out", 32'(dout[i]), 32'(e.dat));
                    pulse_cyc[i] = cyc;
                end
            end
        end
    end

    task automatic expect_byte(input int i, input logic [7:0] b);
        exp_t e;
        e.inst = i; e.err = 1'b0; e.dat = b;
        q.push_back(e);
        last_good[i] = b;
    endtask

    task automatic expect_err(input int i);
        exp_t e;
        e.inst = i; e.err = 1'b1; e.dat = last_good[i];
        q.push_back(e);
    endtask

    task automatic hold(input int i, input logic v, input int n);
        rxd[i] = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [7:0] b, input logic stop, input int bl, output int t0);
        t0 = cyc;
        hold(i, 1'b0, bl);
        for (int k = 0; k < 8; k++) hold(i, b[k], bl);
        hold(i, stop, bl);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (n > 0) #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; rxd[i] = 1'b1; last_good[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("reset_data_out", 32'(dout[i]), 32'h00);
            chk("reset_data_valid", 32'(dv[i]), 32'd0);
            chk("reset_frame_err", 32'(fe[i]), 32'd0);
            chk("reset_busy", 32'(busy[i]), 32'd0);
        end
        @(posedge clk);
        #1;

        // Loopback pattern at the default rate: 55 then CC eleven bit periods later.
        expect_byte(0, 8'h55);
        send(0, 8'h55, 1'b1, 1302, t0);
        chk("latency_default", 32'(pulse_cyc[0] - t0), 32'd12372);
        hold(0, 1'b1, 1302);
        expect_byte(0, 8'hCC);
        send(0, 8'hCC, 1'b1, 1302, t0);
        drain(2000);
        hold(0, 1'b1, 100);

        // False start: 300 low clocks; start check lands 3 + 651 edges after the fall.
        rxd[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("busy_before_detect", 32'(busy[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("busy_rise", 32'(busy[0]), 32'd1);
        repeat (297) @(posedge clk);
        #1;
        rxd[0] = 1'b1;
        repeat (353) @(posedge clk);
        @(negedge clk);
        chk("false_start_busy_held", 32'(busy[0]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("false_start_busy_fall", 32'(busy[0]), 32'd0);
        @(posedge clk);
        #1;
        hold(0, 1'b1, 1400);

        // Framing error after a good byte, line held low, then recovery.
        expect_byte(1, 8'h5A);
        send(1, 8'h5A, 1'b1, 100, t0);
        hold(1, 1'b1, 100);
        expect_err(1);
        send(1, 8'hA3, 1'b0, 100, t0);
        hold(1, 1'b0, 500);
        @(negedge clk);
        chk("break_busy_held", 32'(busy[1]), 32'd1);
        chk("break_data_out_kept", 32'(dout[1]), 32'h5A);
        @(posedge clk);
        #1;
        rxd[1] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("break_busy_until_release", 32'(busy[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("break_busy_fall", 32'(busy[1]), 32'd0);
        @(posedge clk);
        #1;
        hold(1, 1'b1, 100);
        expect_byte(1, 8'h3C);
        send(1, 8'h3C, 1'b1, 100, t0);
        hold(1, 1'b1, 100);
        drain(500);

        // Reset during data bit 4 of F5; bits 4..7 are high so the tail cannot look like a start.
        hold(1, 1'b0, 100);
        hold(1, 1'b1, 100);
        hold(1, 1'b0, 100);
        hold(1, 1'b1, 100);
        hold(1, 1'b0, 100);
        hold(1, 1'b1, 50);
        chk("busy_midframe", 32'(busy[1]), 32'd1);
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        @(negedge clk);
        chk("midreset_data_out", 32'(dout[1]), 32'h00);
        chk("midreset_data_valid", 32'(dv[1]), 32'd0);
        chk("midreset_frame_err", 32'(fe[1]), 32'd0);
        chk("midreset_busy", 32'(busy[1]), 32'd0);
        last_good[1] = 8'h00;
        @(posedge clk);
        #1;
        hold(1, 1'b1, 500);
        expect_byte(1, 8'hF0);
        send(1, 8'hF0, 1'b1, 100, t0);
        hold(1, 1'b1, 100);
        drain(500);

        // Smallest bit periods: latency is exactly 2 + CLKS/2 + 9*CLKS + 1.
        expect_byte(2, 8'h96);
        send(2, 8'h96, 1'b1, 5, t0);
        hold(2, 1'b1, 5);
        chk("latency_cpb5", 32'(pulse_cyc[2] - t0), 32'd50);
        expect_byte(3, 8'h96);
        send(3, 8'h96, 1'b1, 4, t0);
        hold(3, 1'b1, 4);
        chk("latency_cpb4", 32'(pulse_cyc[3] - t0), 32'd41);
        drain(100);

        // Gapless stream at the default rate with +/-2% transmitter skew.
        expect_byte(0, 8'h00);
        send(0, 8'h00, 1'b1, 1328, t0);
        expect_byte(0, 8'hFF);
        send(0, 8'hFF, 1'b1, 1276, t0);
        expect_byte(0, 8'h81);
        send(0, 8'h81, 1'b1, 1328, t0);
        hold(0, 1'b1, 1302);
        drain(2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
